// File: rtl/seg7_scan_bcd.sv
// seg7_scan_bcd: binary -> BCD (sequential double-dabble) with multiplexed 7-segment scan.
// Optional leading-zero blanking when SEG7_LZB_EN is defined.
module seg7_scan_bcd #(
  parameter int DATA_W     = 8,
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              load,
  output logic              busy,
  output logic              ovf,
  output logic [7:0]        seg7,
  output logic [DIGITS-1:0] seg7_sel
);
  localparam int BW = DIGITS * 4;
  localparam int CW = $clog2(DATA_W + 1);
  localparam int TW = $clog2(SCAN_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [7:0] SEG_OFF = ACTIVE_LOW != 0 ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] SEL_OFF = ACTIVE_LOW != 0 ? '1 : '0;
  typedef enum logic {IDLE, CONV} state_t;
  state_t            state;
  logic [DATA_W-1:0] sh;
  logic [BW-1:0]     bcd, adj, bcd_n, disp_bcd;
  logic              carry, c_out;
  logic [CW-1:0]     bit_cnt;
  logic [TW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic              tick;
  logic [3:0]        nib;
  logic [7:0]        pat;
  logic [DIGITS-1:0] sel_raw;
  function automatic logic [7:0] dec(input logic [3:0] n);
    case (n)
      4'd0: dec = 8'h3F;
      4'd1: dec = 8'h06;
      4'd2: dec = 8'h5B;
      4'd3: dec = 8'h4F;
      4'd4: dec = 8'h66;
      4'd5: dec = 8'h6D;
      4'd6: dec = 8'h7D;
      4'd7: dec = 8'h07;
      4'd8: dec = 8'h7F;
      4'd9: dec = 8'h6F;
      default: dec = 8'h00;
    endcase
  endfunction
  always_comb begin
    adj = bcd;
    for (int d = 0; d < DIGITS; d++)
      adj[d*4 +: 4] = bcd[d*4 +: 4] >= 4'd5 ? bcd[d*4 +: 4] + 4'd3 : bcd[d*4 +: 4];
  end
  // bit shifted out of the top nibble is the overflow carry
  assign {c_out, bcd_n} = {adj, sh[DATA_W-1]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      ovf      <= 1'b0;
      disp_bcd <= '0;
      sh       <= '0;
      bcd      <= '0;
      carry    <= 1'b0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (load) begin
          sh      <= din;
          bcd     <= '0;
          carry   <= 1'b0;
          bit_cnt <= '0;
          busy    <= 1'b1;
          state   <= CONV;
        end
        CONV: begin
          sh      <= sh << 1;
          bcd     <= bcd_n;
          carry   <= carry | c_out;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CW'(DATA_W - 1)) begin
            disp_bcd <= bcd_n;
            ovf      <= carry | c_out;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
      endcase
    end
  end
  assign tick    = cnt == TW'(SCAN_DIV - 1);
  assign nib     = 4'(disp_bcd >> {idx, 2'b00});
  assign sel_raw = DIGITS'(1) << idx;
`ifdef SEG7_LZB_EN
  logic [DIGITS-1:0] blank;
  always_comb begin
    logic z;
    z     = 1'b1;
    blank = '0;
    for (int k = DIGITS - 1; k > 0; k--) begin
      z        = z & (disp_bcd[k*4 +: 4] == 4'd0);
      blank[k] = z;
    end
  end
  assign pat = ovf ? 8'h40 : 1'(blank >> idx) ? 8'h00 : dec(nib);
`else
  assign pat = ovf ? 8'h40 : dec(nib);
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      idx      <= '0;
      seg7     <= SEG_OFF;
      seg7_sel <= SEL_OFF;
    end else begin
      cnt      <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
      seg7     <= pat ^ SEG_OFF;
      seg7_sel <= sel_raw ^ SEL_OFF;
    end
  end
endmodule

// File: tb/tb_seg7_scan_bcd.sv
// tb_seg7_scan_bcd: directed table-driven bench for seg7_scan_bcd (3 parameter sets).
module tb_seg7_scan_bcd;
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] din0, din2, din3;
  logic load0, load2, load3;
  logic busy0, busy2, busy3, ovf0, ovf2, ovf3;
  logic [7:0] seg0, seg2, seg3;
  logic [3:0] sel0, sel3;
  logic [1:0] sel2;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  seg7_scan_bcd #(.DATA_W(8), .DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(0)) u0 (
    .clk(clk), .rst_n(rst_n), .din(din0), .load(load0), .busy(busy0), .ovf(ovf0),
    .seg7(seg0), .seg7_sel(sel0));
  seg7_scan_bcd #(.DATA_W(8), .DIGITS(2), .SCAN_DIV(4), .ACTIVE_LOW(0)) u2 (
    .clk(clk), .rst_n(rst_n), .din(din2), .load(load2), .busy(busy2), .ovf(ovf2),
    .seg7(seg2), .seg7_sel(sel2));
  seg7_scan_bcd #(.DATA_W(8), .DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(1)) u3 (
    .clk(clk), .rst_n(rst_n), .din(din3), .load(load3), .busy(busy3), .ovf(ovf3),
    .seg7(seg3), .seg7_sel(sel3));
  typedef struct {
    logic [7:0]  din;
    logic [31:0] seg;
    int          sig;
  } vec_t;
  vec_t tbl[9];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] exp_seg(input vec_t v, input int k);
    logic [7:0] e;
    e = v.seg[k*8 +: 8];
`ifdef SEG7_LZB_EN
    if (k > 0 && k >= v.sig) e = 8'h00;
`endif
    return e;
  endfunction
  function automatic logic [7:0] cur_sel(input int inst);
    return inst == 0 ? {4'b0, sel0} : inst == 1 ? {6'b0, sel2} : {4'b0, ~sel3};
  endfunction
  function automatic logic [7:0] cur_seg(input int inst);
    return inst == 0 ? seg0 : inst == 1 ? seg2 : seg3;
  endfunction
  task automatic read_digit(input int inst, input int k, output logic [7:0] v);
    int n = 0;
    logic [7:0] want;
    want = 8'(1) << k;
    while (cur_sel(inst) != want && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      checks++;
      failures++;
      $display("FAIL scan_timeout inst%0d digit%0d: sel %0h never reached", inst, k, want);
    end
    v = cur_seg(inst);
  endtask
  task automatic check_display(input vec_t v);
    logic [7:0] s;
    for (int k = 0; k < 4; k++) begin
      read_digit(0, k, s);
      chk($sformatf("din%0d_digit%0d", v.din, k), 32'(s), 32'(exp_seg(v, k)));
    end
    chk($sformatf("din%0d_ovf", v.din), 32'(ovf0), 32'd0);
  endtask
  task automatic run_vec(input vec_t v, input int ign);
    int n = 0;
    @(negedge clk);
    din0  = v.din;
    load0 = 1'b1;
    @(negedge clk);
    load0 = 1'b0;
    din0  = 8'hAA;
    while (busy0 && n < 40) begin
      n++;
      if (ign >= 0 && n == 3) begin
        din0  = 8'(ign);
        load0 = 1'b1;
      end else load0 = 1'b0;
      @(negedge clk);
    end
    load0 = 1'b0;
    chk($sformatf("din%0d_busy_len", v.din), 32'(n), 32'd8);
    check_display(v);
  endtask
  initial begin
    logic [7:0] s, e;
    logic pre;
    int n;
    tbl[0] = '{8'd255, 32'h3F5B6D6D, 3};
    tbl[1] = '{8'd0,   32'h3F3F3F3F, 1};
    tbl[2] = '{8'd5,   32'h3F3F3F6D, 1};
    tbl[3] = '{8'd37,  32'h3F3F4F07, 2};
    tbl[4] = '{8'd99,  32'h3F3F6F6F, 2};
    tbl[5] = '{8'd100, 32'h3F063F3F, 3};
    tbl[6] = '{8'd128, 32'h3F065B7F, 3};
    tbl[7] = '{8'd200, 32'h3F5B3F3F, 3};
    tbl[8] = '{8'd42,  32'h3F3F665B, 2};
    rst_n = 1'b0;
    {load0, load2, load3} = 3'b000;
    {din0, din2, din3} = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy_ovf", {30'd0, busy0, ovf0}, 32'd0);
    chk("rst_seg_sel", {20'd0, seg0, sel0}, 32'd0);
    chk("rst_al_seg_sel", {20'd0, seg3, sel3}, 32'hFFF);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      e = 8'(1) << ((i / 4) % 4);
      chk($sformatf("scan_sel_%0d", i), {24'd0, sel0, sel3}, {24'd0, e[3:0], ~e[3:0]});
    end
    for (int i = 0; i < 9; i++) run_vec(tbl[i], -1);
    run_vec(tbl[3], 99);
    @(negedge clk);
    din3 = 8'd5;
    load3 = 1'b1;
    @(negedge clk);
    load3 = 1'b0;
    n = 0;
    while (busy3 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("al_busy_len", 32'(n), 32'd8);
    read_digit(2, 0, s);
    chk("al_digit0", 32'(s), 32'h92);
    read_digit(2, 1, s);
`ifdef SEG7_LZB_EN
    chk("al_digit1", 32'(s), 32'hFF);
`else
    chk("al_digit1", 32'(s), 32'hC0);
`endif
    @(negedge clk);
    din2 = 8'd200;
    load2 = 1'b1;
    @(negedge clk);
    load2 = 1'b0;
    n = 0;
    pre = 1'b1;
    while (busy2 && n < 40) begin
      n++;
      pre = ovf2;
      @(negedge clk);
    end
    chk("d2_busy_len", 32'(n), 32'd8);
    chk("d2_ovf_before", 32'(pre), 32'd0);
    chk("d2_ovf_after", 32'(ovf2), 32'd1);
    for (int k = 0; k < 2; k++) begin
      read_digit(1, k, s);
      chk($sformatf("d2_dash%0d", k), 32'(s), 32'h40);
    end
    @(negedge clk);
    din2 = 8'd99;
    load2 = 1'b1;
    @(negedge clk);
    load2 = 1'b0;
    n = 0;
    while (busy2 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("d2_99_ovf", 32'(ovf2), 32'd0);
    for (int k = 0; k < 2; k++) begin
      read_digit(1, k, s);
      chk($sformatf("d2_99_digit%0d", k), 32'(s), 32'h6F);
    end
    @(negedge clk);
    din0 = 8'd123;
    load0 = 1'b1;
    @(negedge clk);
    load0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("midconv_busy", 32'(busy0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_sel", 32'(sel0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_display(tbl[1]);
    run_vec(tbl[8], -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
